// File: rtl/code_vault_pkg.sv
// code_vault_pkg: shared types, defaults and request arbitration
// for the passcode vault.
package code_vault_pkg;

    localparam int DIGITS_DEF  = 4;
    localparam int DIGIT_W_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        DELETE,
        COMPARE,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_DEL,
        REQ_SAVE,
        REQ_CMP
    } req_t;

    // Delete outranks save, save outranks compare.
    function automatic req_t pick_req(
        input logic i_del,
        input logic i_save,
        input logic i_cmp
    );
        req_t r;
        r = REQ_NONE;
        if (i_del)       r = REQ_DEL;
        else if (i_save) r = REQ_SAVE;
        else if (i_cmp)  r = REQ_CMP;
        return r;
    endfunction

endpackage

// File: rtl/code_vault_if.sv
// code_vault_if: request/response bundle between controller
// and code_vault.
interface code_vault_if #(
    parameter int DIGITS  = code_vault_pkg::DIGITS_DEF,
    parameter int DIGIT_W = code_vault_pkg::DIGIT_W_DEF
);
    logic                      save_start;
    logic                      delete_start;
    logic                      compare_start;
    logic [DIGITS*DIGIT_W-1:0] entry_code;
    logic [2:0]                entry_len;
    logic                      saver_done;
    logic                      deleter_done;
    logic                      comparator_done;
    logic                      match;
    logic                      error_open;
    logic                      code_valid;
    logic                      lockout;

    modport master (
        output save_start, delete_start, compare_start,
        output entry_code, entry_len,
        input  saver_done, deleter_done, comparator_done,
        input  match, error_open, code_valid, lockout
    );

    modport slave (
        input  save_start, delete_start, compare_start,
        input  entry_code, entry_len,
        output saver_done, deleter_done, comparator_done,
        output match, error_open, code_valid, lockout
    );
endinterface

// File: rtl/code_vault_lockout_timer.sv
// lockout_timer: consecutive-failure counter and timed lockout
// that refuses compares for a fixed number of cycles.
module lockout_timer #(
    parameter int MAX_FAIL    = 3,
    parameter int LOCKOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_fail_pulse,
    input  logic i_pass_pulse,
    output logic o_lockout
);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int TW = $clog2(LOCKOUT_CYC + 1);

    logic [FW-1:0] r_fail_cnt;
    logic [TW-1:0] r_timer;
    logic          r_lockout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fail_cnt <= '0;
            r_timer    <= '0;
            r_lockout  <= 1'b0;
        end else begin
            // Lockout releases the cycle after the timer hits zero.
            if (r_lockout) begin
                if (r_timer == '0) r_lockout <= 1'b0;
                else               r_timer   <= r_timer - 1'b1;
            end
            if (i_pass_pulse) begin
                r_fail_cnt <= '0;
            end else if (i_fail_pulse) begin
                if (r_fail_cnt >= FW'(MAX_FAIL - 1)) begin
                    r_fail_cnt <= '0;
                    r_lockout  <= 1'b1;
                    r_timer    <= TW'(LOCKOUT_CYC);
                end else begin
                    r_fail_cnt <= r_fail_cnt + 1'b1;
                end
            end
        end
    end

    assign o_lockout = r_lockout;

endmodule

// File: rtl/code_vault.sv
// code_vault: serial passcode store, erase and compare engine
// with failure-driven lockout.
module code_vault
    import code_vault_pkg::*;
#(
    parameter int DIGITS      = DIGITS_DEF,
    parameter int DIGIT_W     = DIGIT_W_DEF,
    parameter int MAX_FAIL    = 3,
    parameter int LOCKOUT_CYC = 1000
) (
    input  logic        clk,
    input  logic        reset,
    code_vault_if.slave bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [2:0]       FULL_LEN = 3'(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t r_state, w_state_nxt;
    req_t   r_op, w_req, w_op;

    logic [IDX_W-1:0]   r_idx;
    logic [DIGIT_W-1:0] r_code [DIGITS];
    logic [DIGIT_W-1:0] r_sh   [DIGITS];

    logic r_acc, r_match, r_err, r_valid;
    logic r_sv_done, r_dl_done, r_cp_done;
    logic w_last, w_eq, w_len_ok, w_fail, w_pass;
    logic w_to_resp, w_lockout;

    always_comb begin
        w_state_nxt = r_state;
        w_fail      = 1'b0;
        w_pass      = 1'b0;
        w_last      = (r_idx == LAST_IDX);
        w_eq        = (r_code[r_idx] == r_sh[r_idx]);
        w_len_ok    = (bus.entry_len == FULL_LEN);
        w_req       = pick_req(bus.delete_start, bus.save_start,
                               bus.compare_start);
        unique case (r_state)
            IDLE: begin
                unique case (w_req)
                    REQ_DEL:
                        w_state_nxt = r_valid ? DELETE : RESP;
                    REQ_SAVE:
                        w_state_nxt = (r_valid || !w_len_ok) ? RESP : SAVE;
                    REQ_CMP: begin
                        if (w_lockout || !r_valid) begin
                            w_state_nxt = RESP;
                        end else if (!w_len_ok) begin
                            w_state_nxt = RESP;
                            w_fail      = 1'b1;
                        end else begin
                            w_state_nxt = COMPARE;
                        end
                    end
                    default: ;
                endcase
            end
            SAVE, DELETE: begin
                if (w_last) w_state_nxt = RESP;
            end
            COMPARE: begin
                if (w_last) begin
                    w_state_nxt = RESP;
                    w_pass      = r_acc & w_eq;
                    w_fail      = ~(r_acc & w_eq);
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        w_op      = (r_state == IDLE) ? w_req : r_op;
        w_to_resp = (w_state_nxt == RESP) && (r_state != RESP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op      <= REQ_NONE;
            r_idx     <= '0;
            r_acc     <= 1'b0;
            r_match   <= 1'b0;
            r_err     <= 1'b0;
            r_valid   <= 1'b0;
            r_sv_done <= 1'b0;
            r_dl_done <= 1'b0;
            r_cp_done <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                r_code[i] <= '0;
                r_sh[i]   <= '0;
            end
        end else begin
            r_sv_done <= w_to_resp && (w_op == REQ_SAVE);
            r_dl_done <= w_to_resp && (w_op == REQ_DEL);
            r_cp_done <= w_to_resp && (w_op == REQ_CMP);
            unique case (r_state)
                IDLE: begin
                    if (w_req != REQ_NONE) begin
                        r_op  <= w_req;
                        r_idx <= '0;
                        for (int i = 0; i < DIGITS; i++)
                            r_sh[i] <= bus.entry_code[i*DIGIT_W +: DIGIT_W];
                        if (w_req == REQ_SAVE && w_state_nxt == RESP)
                            r_err <= 1'b1;
                        if (w_req == REQ_DEL && w_state_nxt == RESP)
                            r_err <= 1'b0;
                        if (w_req == REQ_CMP) begin
                            r_match <= 1'b0;
                            r_acc   <= 1'b1;
                        end
                    end
                end
                SAVE: begin
                    r_code[r_idx] <= r_sh[r_idx];
                    r_idx         <= w_last ? '0 : r_idx + 1'b1;
                    if (w_last) r_valid <= 1'b1;
                end
                DELETE: begin
                    r_code[r_idx] <= '0;
                    r_idx         <= w_last ? '0 : r_idx + 1'b1;
                    if (w_last) begin
                        r_valid <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                COMPARE: begin
                    r_acc <= r_acc & w_eq;
                    r_idx <= w_last ? '0 : r_idx + 1'b1;
                    if (w_last) r_match <= r_acc & w_eq;
                end
                default: ;
            endcase
        end
    end

    lockout_timer #(
        .MAX_FAIL    (MAX_FAIL),
        .LOCKOUT_CYC (LOCKOUT_CYC)
    ) u_lockout (
        .clk          (clk),
        .reset        (reset),
        .i_fail_pulse (w_fail),
        .i_pass_pulse (w_pass),
        .o_lockout    (w_lockout)
    );

    assign bus.saver_done      = r_sv_done;
    assign bus.deleter_done    = r_dl_done;
    assign bus.comparator_done = r_cp_done;
    assign bus.match           = r_match;
    assign bus.error_open      = r_err;
    assign bus.code_valid      = r_valid;
    assign bus.lockout         = w_lockout;

endmodule

// File: doc/code_vault.md
# code_vault

Passcode storage and verification engine for the smart lock. Services the one-cycle `save_start` / `delete_start` / `compare_start` requests issued by `controller`. Returns the `saver_done` / `deleter_done` / `comparator_done`, `match` and `error_open` responses that `controller` consumes. Digits are written, cleared and compared serially with fixed latency. A failed-attempt counter forces a timed lockout.

## Interface
Parameters:
- DIGITS, 4, passcode length in digits
- DIGIT_W, 4, bits per digit (BCD)
- MAX_FAIL, 3, consecutive mismatches that trigger lockout
- LOCKOUT_CYC, 1000, lockout duration in clk cycles (must be ≥ 1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- save_start  in  1  one-cycle request: store entry_code
- delete_start  in  1  one-cycle request: erase stored code
- compare_start  in  1  one-cycle request: check entry_code against stored code
- entry_code  in  DIGITS*DIGIT_W  keypad digits; digit 0 in LSBs
- entry_len  in  3  number of digits entered (the keypad counter)
- saver_done  out  1  one-cycle completion of save
- deleter_done  out  1  one-cycle completion of delete
- comparator_done  out  1  one-cycle completion of compare
- match  out  1  compare result; valid from the comparator_done cycle onward
- error_open  out  1  sticky: a save was refused
- code_valid  out  1  a code is stored
- lockout  out  1  compares are refused

## Operation
- States: IDLE, SAVE, DELETE, COMPARE, RESP.
- Requests are accepted only in IDLE.
  - Priority when several start inputs are high together: delete > save > compare. Lower-priority requests are dropped.
  - Starts that arrive in any other state are ignored and produce no done pulse.
- On acceptance, entry_code and entry_len are latched into a shadow register. The inputs may change afterwards.
- The digit index idx counts 0..DIGITS-1 and wraps to 0 on leaving SAVE, DELETE or COMPARE.
- SAVE:
  - If code_valid=1 or entry_len≠DIGITS: go straight to RESP, set error_open, leave the stored code unchanged.
  - Otherwise: write one digit per cycle; set code_valid on the last write.
- DELETE:
  - Clear one digit per cycle.
  - On completion: clear code_valid and error_open.
  - If code_valid=0: go straight to RESP and clear error_open.
- COMPARE:
  - match is cleared on acceptance.
  - If lockout=1 or code_valid=0: go straight to RESP with match=0. The fail counter is unchanged.
  - If entry_len≠DIGITS: go straight to RESP with match=0 and count a failure.
  - Otherwise: compare one digit per cycle, accumulating an AND. Always run all DIGITS cycles; there is no early exit.
  - Result on completion:
    - all digits equal → match=1, fail_cnt cleared.
    - any mismatch → match=0, fail_cnt+1.
- match holds its value until the next accepted compare or reset.
- Lockout:
  - When fail_cnt reaches MAX_FAIL: lockout=1, timer loaded with LOCKOUT_CYC, fail_cnt cleared.
  - The timer decrements every cycle. lockout drops in the cycle after the timer reaches 0.
  - Delete and save remain serviceable during lockout.
- RESP: pulse the matching done output for one cycle, then return to IDLE.
- Widths:
  - fail_cnt: $clog2(MAX_FAIL+1)
  - timer: $clog2(LOCKOUT_CYC+1)
  - idx: $clog2(DIGITS)
  - Counters saturate and never wrap.
- Reset (asserted at any time, including mid-operation):
  - state IDLE; stored code all zeros; all counters 0.
  - all outputs 0: saver_done, deleter_done, comparator_done, match, error_open, code_valid, lockout.
  - No done pulse is issued for the aborted operation.

## Timing
- Cycle 0 is the cycle in which a start is sampled high in IDLE.
- Full operation: digits processed in cycles 1..DIGITS; done high only in cycle DIGITS+1; back in IDLE at DIGITS+2. With DIGITS=4, done is in cycle 5.
- Short-circuit path (refused or no-op): done high only in cycle 1; back in IDLE at 2.
- Output update cycles:
  - code_valid rises or falls in the same cycle as the corresponding done.
  - error_open sets in the cycle of the refused saver_done.
  - match is valid in the comparator_done cycle.
  - lockout rises in the comparator_done cycle of the MAX_FAIL-th failure.
- All outputs are registered. There are no combinational input-to-output paths.

## Structure
- Package code_vault_pkg holds the state enum type, the DIGITS/DIGIT_W defaults and the request-priority encoding.
- Sub-module lockout_timer holds fail_cnt, the down-counter and the lockout flag.
  - Inputs: fail_pulse, pass_pulse.
  - Output: lockout.
- The FSM, shadow register and digit store remain in code_vault.

## Test plan
- Save 4'h1,2,3,4 (entry_len=4) from reset → saver_done in cycle 5, code_valid=1; compare same code → comparator_done in cycle 5, match=1.
- Second save while code_valid=1 → saver_done in cycle 1, error_open=1, stored code unchanged (a subsequent compare of 1234 gives match=1); then delete → deleter_done in cycle 5, code_valid=0, error_open=0.
- Three compares of 1235 → match=0 each, lockout=1 on the third done; a compare of the correct code during lockout → done in cycle 1, match=0; after LOCKOUT_CYC cycles lockout=0 and the correct code gives match=1.
- delete_start, save_start and compare_start high together in IDLE → only deleter_done pulses; starts issued mid-SAVE produce no done pulse.
- compare with entry_len=3 → done in cycle 1, match=0, one failure counted; entry_code changed during COMPARE does not affect the result.
- reset driven low in cycle 2 of a SAVE → all outputs 0, code_valid=0, no saver_done; after release a new save completes normally.
